// File: rtl/ualink_dpmem_v2.sv
// True dual-port byte-enabled RAM with post-reset clear sweep and 1/2-cycle read latency.
// Define UALINK_DPMEM_COLLISION_EN to build the same-address conflict detector.
module ualink_dpmem_v2 #(
    parameter int DPADDR_WIDTH = 8,
    parameter int DPDATA_WIDTH = 64,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_MODE   = 0
) (
    input  logic                        axi_aclk,
    input  logic                        axi_reset,
    input  logic                        en_a,
    input  logic                        we_a,
    input  logic [DPDATA_WIDTH/8-1:0]   be_a,
    input  logic [DPADDR_WIDTH-1:0]     addr_a,
    input  logic [DPDATA_WIDTH-1:0]     din_a,
    input  logic                        en_b,
    input  logic                        we_b,
    input  logic [DPDATA_WIDTH/8-1:0]   be_b,
    input  logic [DPADDR_WIDTH-1:0]     addr_b,
    input  logic [DPDATA_WIDTH-1:0]     din_b,
    output logic [DPDATA_WIDTH-1:0]     dout_a,
    output logic [DPDATA_WIDTH-1:0]     dout_b,
    output logic                        rvalid_a,
    output logic                        rvalid_b,
    output logic                        init_busy,
    output logic                        collision,
    output logic [15:0]                 collision_cnt
);
    localparam int DEPTH = 2 ** DPADDR_WIDTH;
    localparam int NB    = DPDATA_WIDTH / 8;

    logic [DPDATA_WIDTH-1:0] mem [DEPTH];
    logic [DPADDR_WIDTH-1:0] sweep_cnt;
    logic                    req_a, req_b, wr_a, wr_b;
    logic [DPDATA_WIDTH-1:0] old_a, old_b;
    logic [DPDATA_WIDTH-1:0] dout_a_p1, dout_b_p1;
    logic                    vld_a_p1, vld_b_p1;

    function automatic logic [DPDATA_WIDTH-1:0] merge_bytes(
        input logic [DPDATA_WIDTH-1:0] old_w,
        input logic [DPDATA_WIDTH-1:0] new_w,
        input logic [NB-1:0]           be
    );
        logic [DPDATA_WIDTH-1:0] r;
        for (int i = 0; i < NB; i++)
            r[i*8 +: 8] = be[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
        return r;
    endfunction

    // Read result for one port; no-change mode on a write keeps the current output word.
    function automatic logic [DPDATA_WIDTH-1:0] next_dout(
        input logic                    we,
        input logic [DPDATA_WIDTH-1:0] old_w,
        input logic [DPDATA_WIDTH-1:0] din,
        input logic [NB-1:0]           be,
        input logic [DPDATA_WIDTH-1:0] cur
    );
        if (!we)
            return old_w;
        else if (WRITE_MODE == 0)
            return merge_bytes(old_w, din, be);
        else if (WRITE_MODE == 1)
            return old_w;
        else
            return cur;
    endfunction

    assign req_a = en_a & ~init_busy & ~axi_reset;
    assign req_b = en_b & ~init_busy & ~axi_reset;
    assign wr_a  = req_a & we_a;
    assign wr_b  = req_b & we_b;
    assign old_a = mem[addr_a];
    assign old_b = mem[addr_b];

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            sweep_cnt <= '0;
            init_busy <= 1'b1;
        end else if (init_busy) begin
            sweep_cnt <= sweep_cnt + DPADDR_WIDTH'(1);
            if (sweep_cnt == '1)
                init_busy <= 1'b0;
        end
    end

    // Port B bytes are written first so port A overrides on bytes both ports enable.
    always_ff @(posedge axi_aclk) begin
        if (init_busy && !axi_reset) begin
            mem[sweep_cnt] <= '0;
        end else begin
            for (int i = 0; i < NB; i++)
                if (wr_b && be_b[i])
                    mem[addr_b][i*8 +: 8] <= din_b[i*8 +: 8];
            for (int i = 0; i < NB; i++)
                if (wr_a && be_a[i])
                    mem[addr_a][i*8 +: 8] <= din_a[i*8 +: 8];
        end
    end

    // Stage p1: registered array read
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            vld_a_p1  <= 1'b0;
            vld_b_p1  <= 1'b0;
            dout_a_p1 <= '0;
            dout_b_p1 <= '0;
        end else begin
            vld_a_p1 <= req_a;
            vld_b_p1 <= req_b;
            if (req_a)
                dout_a_p1 <= next_dout(we_a, old_a, din_a, be_a, dout_a_p1);
            if (req_b)
                dout_b_p1 <= next_dout(we_b, old_b, din_b, be_b, dout_b_p1);
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DPDATA_WIDTH-1:0] dout_a_p2, dout_b_p2;
            logic                    vld_a_p2, vld_b_p2;

            // Stage p2: extra output register
            always_ff @(posedge axi_aclk) begin
                if (axi_reset) begin
                    vld_a_p2  <= 1'b0;
                    vld_b_p2  <= 1'b0;
                    dout_a_p2 <= '0;
                    dout_b_p2 <= '0;
                end else begin
                    vld_a_p2 <= vld_a_p1;
                    vld_b_p2 <= vld_b_p1;
                    if (vld_a_p1)
                        dout_a_p2 <= dout_a_p1;
                    if (vld_b_p1)
                        dout_b_p2 <= dout_b_p1;
                end
            end

            assign dout_a   = dout_a_p2;
            assign dout_b   = dout_b_p2;
            assign rvalid_a = vld_a_p2;
            assign rvalid_b = vld_b_p2;
        end else begin : g_lat1
            assign dout_a   = dout_a_p1;
            assign dout_b   = dout_b_p1;
            assign rvalid_a = vld_a_p1;
            assign rvalid_b = vld_b_p1;
        end
    endgenerate

`ifdef UALINK_DPMEM_COLLISION_EN
    logic        conflict;
    logic        coll_r;
    logic [15:0] coll_cnt_r;

    assign conflict = req_a & req_b & (addr_a == addr_b) & (we_a | we_b);

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            coll_r     <= 1'b0;
            coll_cnt_r <= '0;
        end else if (conflict) begin
            coll_r <= 1'b1;
            if (coll_cnt_r != 16'hFFFF)
                coll_cnt_r <= coll_cnt_r + 16'd1;
        end
    end

    assign collision     = coll_r;
    assign collision_cnt = coll_cnt_r;
`else
    assign collision     = 1'b0;
    assign collision_cnt = '0;
`endif

endmodule

// File: tb/tb_ualink_dpmem_v2.sv
// Bench for ualink_dpmem_v2: four instances (write mode x latency) driven in lockstep against one array-based model.
`timescale 1ns/1ps
module tb_ualink_dpmem_v2;
    localparam int AW    = 8;
    localparam int DW    = 64;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 256;
    localparam int NI    = 4;
`ifdef UALINK_DPMEM_COLLISION_EN
    localparam bit COLL_EN = 1'b1;
`else
    localparam bit COLL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          en_a, we_a, en_b, we_b;
    logic [NB-1:0] be_a, be_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] din_a, din_b;

    logic [DW-1:0] dout_a_w [NI];
    logic [DW-1:0] dout_b_w [NI];
    logic          rvalid_a_w [NI];
    logic          rvalid_b_w [NI];
    logic          busy_w [NI];
    logic          coll_w [NI];
    logic [15:0]   ccnt_w [NI];

    always #5 clk = ~clk;

    // Instance g: write mode {0,1,2,2}, read latency {1,2,1,2}
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int WM = (g == 3) ? 2 : g;
        localparam int RL = (g == 1 || g == 3) ? 2 : 1;
        ualink_dpmem_v2 #(
            .DPADDR_WIDTH(AW), .DPDATA_WIDTH(DW), .READ_LATENCY(RL), .WRITE_MODE(WM)
        ) u_dut (
            .axi_aclk(clk), .axi_reset(rst),
            .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
            .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
            .dout_a(dout_a_w[g]), .dout_b(dout_b_w[g]),
            .rvalid_a(rvalid_a_w[g]), .rvalid_b(rvalid_b_w[g]),
            .init_busy(busy_w[g]), .collision(coll_w[g]), .collision_cnt(ccnt_w[g])
        );
    end

    function automatic int wm_of(input int g);
        return (g == 3) ? 2 : g;
    endfunction
    function automatic int rl_of(input int g);
        return (g == 1 || g == 3) ? 2 : 1;
    endfunction

    // Reference model state
    logic [DW-1:0] mem_m [DEPTH];
    bit            busy_m;
    int            sweep_m;
    bit            coll_m;
    logic [15:0]   ccnt_m;
    bit            last_v [NI][2];
    logic [DW-1:0] last_d [NI][2];
    bit            out_v  [NI][2];
    logic [DW-1:0] out_d  [NI][2];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        for (int i = 0; i < NB; i++)
            r[i*8 +: 8] = be[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
        return r;
    endfunction

    // Advance model by one clock from the currently driven inputs, clock the DUTs, compare everything.
    task automatic tick();
        bit            req [2];
        bit            we  [2];
        logic [NB-1:0] be  [2];
        logic [AW-1:0] ad  [2];
        logic [DW-1:0] din [2];
        logic [DW-1:0] old [2];
        req[0] = en_a; we[0] = we_a; be[0] = be_a; ad[0] = addr_a; din[0] = din_a;
        req[1] = en_b; we[1] = we_b; be[1] = be_b; ad[1] = addr_b; din[1] = din_b;
        if (rst) begin
            busy_m = 1; sweep_m = 0; coll_m = 0; ccnt_m = 16'd0;
            for (int g = 0; g < NI; g++)
                for (int p = 0; p < 2; p++) begin
                    last_v[g][p] = 0; last_d[g][p] = '0; out_v[g][p] = 0; out_d[g][p] = '0;
                end
        end else begin
            if (busy_m) begin
                req[0] = 0; req[1] = 0;
                mem_m[sweep_m] = '0;
                sweep_m++;
                if (sweep_m == DEPTH) busy_m = 0;
            end
            old[0] = mem_m[ad[0]];
            old[1] = mem_m[ad[1]];
            if (COLL_EN && req[0] && req[1] && ad[0] == ad[1] && (we[0] || we[1])) begin
                coll_m = 1;
                if (ccnt_m != 16'hFFFF) ccnt_m = ccnt_m + 16'd1;
            end
            for (int g = 0; g < NI; g++)
                for (int p = 0; p < 2; p++) begin
                    if (rl_of(g) == 2) begin
                        out_v[g][p] = last_v[g][p];
                        if (last_v[g][p]) out_d[g][p] = last_d[g][p];
                    end
                    last_v[g][p] = req[p];
                    if (req[p]) begin
                        if (!we[p])               last_d[g][p] = old[p];
                        else if (wm_of(g) == 0)   last_d[g][p] = merge(old[p], din[p], be[p]);
                        else if (wm_of(g) == 1)   last_d[g][p] = old[p];
                    end
                    if (rl_of(g) == 1) begin
                        out_v[g][p] = last_v[g][p];
                        out_d[g][p] = last_d[g][p];
                    end
                end
            if (req[1] && we[1]) mem_m[ad[1]] = merge(mem_m[ad[1]], din[1], be[1]);
            if (req[0] && we[0]) mem_m[ad[0]] = merge(mem_m[ad[0]], din[0], be[0]);
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("rvalid_a[%0d]", g), 64'(rvalid_a_w[g]), 64'(out_v[g][0]));
            chk($sformatf("rvalid_b[%0d]", g), 64'(rvalid_b_w[g]), 64'(out_v[g][1]));
            chk($sformatf("dout_a[%0d]", g), dout_a_w[g], out_d[g][0]);
            chk($sformatf("dout_b[%0d]", g), dout_b_w[g], out_d[g][1]);
            chk($sformatf("init_busy[%0d]", g), 64'(busy_w[g]), 64'(busy_m));
            chk($sformatf("collision[%0d]", g), 64'(coll_w[g]), 64'(coll_m));
            chk($sformatf("collision_cnt[%0d]", g), 64'(ccnt_w[g]), 64'(ccnt_m));
        end
    endtask

    task automatic idle();
        en_a = 0; we_a = 0; be_a = '0; addr_a = '0; din_a = '0;
        en_b = 0; we_b = 0; be_b = '0; addr_b = '0; din_b = '0;
    endtask

    task automatic wait_init();
        int n = 0;
        do begin
            tick();
            n++;
        end while (busy_w[0] === 1'b1 && n < 300);
        chk("init_cycles", 64'(n), 64'd256);
    endtask

    typedef struct {
        logic          en_a, we_a;
        logic [NB-1:0] be_a;
        logic [AW-1:0] addr_a;
        logic [DW-1:0] din_a;
        logic          en_b, we_b;
        logic [NB-1:0] be_b;
        logic [AW-1:0] addr_b;
        logic [DW-1:0] din_b;
        logic          chk_a, chk_b;
        logic [DW-1:0] exp_a, exp_b;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // Expectations are for instance 0 (write-first, latency 1), checked right after each edge.
        tbl[0]  = '{1,1,8'hFF,8'h10,64'hDEADBEEF_CAFEBABE, 0,0,8'h00,8'h00,64'h0, 1,0, 64'hDEADBEEF_CAFEBABE, 64'h0};
        tbl[1]  = '{0,0,8'h00,8'h00,64'h0, 1,0,8'h00,8'h10,64'h0, 0,1, 64'h0, 64'hDEADBEEF_CAFEBABE};
        tbl[2]  = '{1,1,8'hFF,8'h20,64'h11111111_11111111, 0,0,8'h00,8'h00,64'h0, 1,0, 64'h11111111_11111111, 64'h0};
        tbl[3]  = '{1,1,8'h0F,8'h20,64'hFFFFFFFF_FFFFFFFF, 0,0,8'h00,8'h00,64'h0, 1,0, 64'h11111111_FFFFFFFF, 64'h0};
        tbl[4]  = '{0,0,8'h00,8'h00,64'h0, 1,0,8'h00,8'h20,64'h0, 0,1, 64'h0, 64'h11111111_FFFFFFFF};
        tbl[5]  = '{1,1,8'hFF,8'h30,64'hAAAAAAAA_BBBBBBBB, 0,0,8'h00,8'h00,64'h0, 1,0, 64'hAAAAAAAA_BBBBBBBB, 64'h0};
        tbl[6]  = '{1,1,8'hFF,8'h30,64'h1, 0,0,8'h00,8'h00,64'h0, 1,0, 64'h1, 64'h0};
        tbl[7]  = '{1,1,8'hFF,8'h50,64'h5, 1,0,8'h00,8'h50,64'h0, 1,1, 64'h5, 64'h0};
        tbl[8]  = '{0,0,8'h00,8'h00,64'h0, 1,0,8'h00,8'h50,64'h0, 0,1, 64'h0, 64'h5};
        tbl[9]  = '{1,1,8'hFF,8'h60,64'hA, 1,1,8'hFF,8'h60,64'hB, 1,0, 64'hA, 64'h0};
        tbl[10] = '{1,0,8'h00,8'h60,64'h0, 0,0,8'h00,8'h00,64'h0, 1,0, 64'hA, 64'h0};
        tbl[11] = '{1,1,8'h00,8'h70,64'hFFFFFFFF_FFFFFFFF, 1,0,8'h00,8'h70,64'h0, 1,1, 64'h0, 64'h0};
        tbl[12] = '{1,0,8'h00,8'hFF,64'h0, 1,0,8'h00,8'h05,64'h0, 1,1, 64'h0, 64'h0};

        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
        // Requests during the sweep must be ignored: try to write ones to 0x05
        en_a = 1; we_a = 1; be_a = '1; addr_a = 8'h05; din_a = '1;
        en_b = 1; we_b = 0; addr_b = 8'h05;
        wait_init();
        idle();

        for (int i = 0; i < 13; i++) begin
            en_a = tbl[i].en_a; we_a = tbl[i].we_a; be_a = tbl[i].be_a; addr_a = tbl[i].addr_a; din_a = tbl[i].din_a;
            en_b = tbl[i].en_b; we_b = tbl[i].we_b; be_b = tbl[i].be_b; addr_b = tbl[i].addr_b; din_b = tbl[i].din_b;
            tick();
            if (tbl[i].chk_a) begin
                chk($sformatf("tbl%0d_dout_a", i), dout_a_w[0], tbl[i].exp_a);
                chk($sformatf("tbl%0d_rvalid_a", i), 64'(rvalid_a_w[0]), 64'd1);
            end
            if (tbl[i].chk_b) begin
                chk($sformatf("tbl%0d_dout_b", i), dout_b_w[0], tbl[i].exp_b);
                chk($sformatf("tbl%0d_rvalid_b", i), 64'(rvalid_b_w[0]), 64'd1);
            end
        end
        idle();
        tick();
        tick();

        // Randomized traffic on a narrow address window to provoke same-address cases
        for (int i = 0; i < 1500; i++) begin
            rst    = ($urandom_range(0, 399) == 0);
            en_a   = $urandom_range(0, 3) != 0;
            we_a   = $urandom_range(0, 1) == 1;
            be_a   = NB'($urandom);
            addr_a = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            din_a  = {$urandom, $urandom};
            en_b   = $urandom_range(0, 3) != 0;
            we_b   = $urandom_range(0, 1) == 1;
            be_b   = NB'($urandom);
            addr_b = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            din_b  = {$urandom, $urandom};
            tick();
        end
        rst = 0;
        idle();
        if (busy_w[0] === 1'b1) wait_init();

        // Back-to-back read burst, then reset in the middle of it
        for (int i = 0; i < 4; i++) begin
            en_a = 1; we_a = 0; addr_a = AW'(i);
            en_b = 1; we_b = 0; addr_b = AW'(8'h10);
            tick();
        end
        rst = 1;
        tick();
        chk("reset_rvalid_a", 64'(rvalid_a_w[1]), 64'd0);
        chk("reset_dout_b", dout_b_w[0], 64'h0);
        chk("reset_init_busy", 64'(busy_w[0]), 64'd1);
        chk("reset_collision", 64'(coll_w[0]), 64'd0);
        rst = 0;
        idle();
        wait_init();
        en_b = 1; addr_b = 8'h10;
        tick();
        chk("post_reset_read", dout_b_w[0], 64'h0);
        idle();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
